// File: rtl/lfsr_div_ctrl.sv
// LFSR clock-divider controller: a 27-bit XNOR LFSR reloaded from a seed every period
// drives a tick and a toggle/pulse divided output; new configs take effect only on period boundaries.
module lfsr_div_ctrl #(
    parameter int LFSR_W = 27,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic              cfg_mode,
    input  logic              stop_req,
    output logic              div,
    output logic              tick,
    output logic              busy,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  period_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [4:0]          s1_q, s1_d;
    logic                match_q, match_d;
    logic [LFSR_W-1:0]   seed_q, seed_d;
    logic                mode_q, mode_d;
    logic [LFSR_W-1:0]   pend_seed_q, pend_seed_d;
    logic                pend_mode_q, pend_mode_d;
    logic                div_q, div_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          s1_or;
    logic                fb;

    assign fb = lfsr_q[26] ^ ~(lfsr_q[4] ^ ~(lfsr_q[1] ^ ~lfsr_q[0]));

    // First zero-detect stage: OR of 6-bit slices, the last slice being the 3 top bits.
    for (genvar gi = 0; gi < 5; gi++) begin : g_zero
        localparam int LO = 6 * gi;
        localparam int HI = (6 * gi + 5 > LFSR_W - 1) ? LFSR_W - 1 : 6 * gi + 5;
        assign s1_or[gi] = |lfsr_q[HI:LO];
    end

    function automatic logic next_div(input logic md, input logic hit, input logic cur);
        if (md)
            return hit;
        return hit ? ~cur : cur;
    endfunction

    always_comb begin
        state_d     = state_q;
        lfsr_d      = match_q ? seed_q : {lfsr_q[LFSR_W-2:0], fb};
        s1_d        = s1_or;
        match_d     = ~|s1_q;
        seed_d      = seed_q;
        mode_d      = mode_q;
        pend_seed_d = pend_seed_q;
        pend_mode_d = pend_mode_q;
        div_d       = div_q;
        tick_d      = match_q && (state_q != IDLE);
        cnt_d       = cnt_q + CNT_W'(tick_d);
        cfg_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                lfsr_d    = lfsr_q;
                // Keep the detector parked at non-match so a held all-zero LFSR
                // cannot fire a reload on the first RUN cycle.
                s1_d      = '1;
                match_d   = 1'b0;
                div_d     = 1'b0;
                if (cfg_valid) begin
                    seed_d  = cfg_seed;
                    mode_d  = cfg_mode;
                    lfsr_d  = cfg_seed;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cfg_ready = ~stop_req;
                div_d     = next_div(mode_q, match_q, div_q);
                if (stop_req) begin
                    state_d = STOP;
                end else if (cfg_valid) begin
                    pend_seed_d = cfg_seed;
                    pend_mode_d = cfg_mode;
                    state_d     = SWITCH;
                end
            end
            SWITCH: begin
                if (stop_req) begin
                    div_d   = next_div(mode_q, match_q, div_q);
                    state_d = STOP;
                end else if (match_q) begin
                    seed_d  = pend_seed_q;
                    mode_d  = pend_mode_q;
                    lfsr_d  = pend_seed_q;
                    div_d   = next_div(pend_mode_q, 1'b1, div_q);
                    state_d = RUN;
                end else begin
                    div_d = next_div(mode_q, 1'b0, div_q);
                end
            end
            default: begin
                if (match_q) begin
                    div_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = next_div(mode_q, 1'b0, div_q);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            s1_q        <= '1;
            match_q     <= 1'b0;
            seed_q      <= '0;
            mode_q      <= 1'b0;
            pend_seed_q <= '0;
            pend_mode_q <= 1'b0;
            div_q       <= 1'b0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            s1_q        <= s1_d;
            match_q     <= match_d;
            seed_q      <= seed_d;
            mode_q      <= mode_d;
            pend_seed_q <= pend_seed_d;
            pend_mode_q <= pend_mode_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
        end
    end

    assign div        = div_q;
    assign tick       = tick_q;
    assign busy       = (state_q != IDLE);
    assign state      = state_q;
    assign period_cnt = cnt_q;

endmodule
